// File: rtl/rsp_rr_arbiter.sv
// Buffers NUM_SRC response producers and drains them round-robin into one response-FIFO write port.
// Latency: 2 cycles from strobe to rsp_write_en. Backpressure: rsp_full stalls grants; src_ready drops per full buffer.

module rsp_buf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module rsp_rr_arbiter #(
  parameter int RSP_WIDTH = 32,
  parameter int NUM_SRC   = 4,
  parameter int BUF_DEPTH = 2,
  parameter int SRC_ID_W  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0]             src_write_en,
  input  logic [NUM_SRC*RSP_WIDTH-1:0]   src_data,
  output logic [NUM_SRC-1:0]             src_ready,
  input  logic                           rsp_full,
  output logic                           rsp_write_en,
  output logic [RSP_WIDTH-1:0]           rsp_data,
  output logic [SRC_ID_W-1:0]            rsp_src_id,
  output logic [NUM_SRC-1:0]             overflow_err
);
  localparam int                  CNT_W    = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(BUF_DEPTH);
  localparam logic [SRC_ID_W-1:0] LAST_SRC = SRC_ID_W'(NUM_SRC - 1);

  logic [NUM_SRC-1:0]   push;
  logic [NUM_SRC-1:0]   pop;
  logic [NUM_SRC-1:0]   eligible;
  logic [RSP_WIDTH-1:0] head_dat [NUM_SRC];
  logic [CNT_W-1:0]     buf_cnt  [NUM_SRC];

  logic [SRC_ID_W-1:0]  last_grant;
  logic [SRC_ID_W-1:0]  grant_id;
  logic                 grant_vld;
  int                   scan_idx;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    rsp_buf_fifo #(
      .WIDTH (RSP_WIDTH),
      .DEPTH (BUF_DEPTH),
      .CNT_W (CNT_W)
    ) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push[g]),
      .push_dat (src_data[g*RSP_WIDTH +: RSP_WIDTH]),
      .pop      (pop[g]),
      .head_dat (head_dat[g]),
      .count    (buf_cnt[g])
    );

    // Ready looks at occupancy only, so a same-cycle pop never frees a slot early.
    assign src_ready[g] = (buf_cnt[g] != FULL_CNT);
    assign eligible[g]  = (buf_cnt[g] != '0);
    assign push[g]      = src_write_en[g] & src_ready[g];
    assign pop[g]       = grant_vld & (grant_id == SRC_ID_W'(g));
  end

  // Scan starts just after the previous winner, giving rotating priority.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = last_grant;
    scan_idx  = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      scan_idx = (int'(last_grant) + k) % NUM_SRC;
      if (!grant_vld && eligible[SRC_ID_W'(scan_idx)]) begin
        grant_vld = 1'b1;
        grant_id  = SRC_ID_W'(scan_idx);
      end
    end
    if (rsp_full) grant_vld = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_write_en <= 1'b0;
      rsp_data     <= '0;
      rsp_src_id   <= '0;
      last_grant   <= LAST_SRC;
      overflow_err <= '0;
    end else begin
      rsp_write_en <= grant_vld;
      overflow_err <= overflow_err | (src_write_en & ~src_ready);
      if (grant_vld) begin
        rsp_data   <= head_dat[grant_id];
        rsp_src_id <= grant_id;
        last_grant <= grant_id;
      end
    end
  end
endmodule

// File: tb/tb_rsp_rr_arbiter.sv
// Scoreboard bench for rsp_rr_arbiter: expected words queued on accepted writes, matched per source on output.

module tb_rsp_rr_arbiter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [3:0]   src_write_en = '0;
  logic [127:0] src_data = '0;
  logic [3:0]   src_ready;
  logic         rsp_full = 1'b0;
  logic         rsp_write_en;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_src_id;
  logic [3:0]   overflow_err;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] dat;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  out_src[$];
  logic [31:0] out_dat[$];
  int          out_cyc[$];
  logic [3:0]  exp_ovf = '0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          mon_idx;

  rsp_rr_arbiter #(
    .RSP_WIDTH (32),
    .NUM_SRC   (4),
    .BUF_DEPTH (2),
    .SRC_ID_W  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_write_en (src_write_en),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .rsp_full     (rsp_full),
    .rsp_write_en (rsp_write_en),
    .rsp_data     (rsp_data),
    .rsp_src_id   (rsp_src_id),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output monitor: match each emitted word against the oldest pending word of its source.
  always @(negedge clk) begin
    if (rst_n && rsp_write_en) begin
      mon_idx = -1;
      for (int i = 0; i < exp_q.size(); i++)
        if (mon_idx < 0 && exp_q[i].src == rsp_src_id) mon_idx = i;
      checks++;
      if (mon_idx < 0) begin
        failures++;
        $display("FAIL sb_unexpected: got src=%0d data=%h, required no pending word for that source", rsp_src_id, rsp_data);
      end else begin
        if (exp_q[mon_idx].dat !== rsp_data) begin
          failures++;
          $display("FAIL sb_data: src=%0d got %h, required %h", rsp_src_id, rsp_data, exp_q[mon_idx].dat);
        end
        exp_q.delete(mon_idx);
      end
      out_src.push_back(rsp_src_id);
      out_dat.push_back(rsp_data);
      out_cyc.push_back(cyc);
    end
  end

  task automatic clear_out();
    out_src.delete();
    out_dat.delete();
    out_cyc.delete();
  endtask

  // Drives one cycle of writes starting just after a rising edge; returns just after the next one.
  task automatic write_cycle(input logic [3:0] mask, input logic [31:0] d0, d1, d2, d3);
    logic [31:0] d [4];
    exp_t e;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    src_write_en = mask;
    for (int i = 0; i < 4; i++) begin
      src_data[i*32 +: 32] = d[i];
      if (mask[i]) begin
        if (src_ready[i]) begin
          e.src = i[1:0];
          e.dat = d[i];
          exp_q.push_back(e);
        end else begin
          exp_ovf[i] = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    src_write_en = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_write_en = '0;
    rsp_full = 1'b0;
    exp_q.delete();
    exp_ovf = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d words still pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rsp_write_en !== 1'b0) begin failures++; $display("FAIL reset_wen: got %b, required 0", rsp_write_en); end
    checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h, required 0", rsp_data); end
    checks++; if (rsp_src_id !== 2'd0) begin failures++; $display("FAIL reset_src_id: got %0d, required 0", rsp_src_id); end
    checks++; if (overflow_err !== 4'b0000) begin failures++; $display("FAIL reset_ovf: got %b, required 0000", overflow_err); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (src_ready !== 4'b1111) begin failures++; $display("FAIL reset_ready: got %b, required 1111", src_ready); end
    checks++; if (rsp_write_en !== 1'b0) begin failures++; $display("FAIL reset_idle_wen: got %b, required 0", rsp_write_en); end
  endtask

  task automatic test_single();
    write_cycle(4'b0001, 32'hA5A5_0001, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (rsp_write_en !== 1'b0) begin failures++; $display("FAIL single_early: wen got %b one cycle after strobe, required 0", rsp_write_en); end
    @(negedge clk);
    checks++; if (rsp_write_en !== 1'b1) begin failures++; $display("FAIL single_wen: got %b, required 1", rsp_write_en); end
    checks++; if (rsp_data !== 32'hA5A5_0001) begin failures++; $display("FAIL single_data: got %h, required a5a50001", rsp_data); end
    checks++; if (rsp_src_id !== 2'd0) begin failures++; $display("FAIL single_src: got %0d, required 0", rsp_src_id); end
    @(negedge clk);
    checks++; if (rsp_write_en !== 1'b0) begin failures++; $display("FAIL single_pulse: got %b, required 0", rsp_write_en); end
    checks++; if (rsp_data !== 32'hA5A5_0001) begin failures++; $display("FAIL single_hold: got %h, required a5a50001", rsp_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_all_four();
    do_reset();
    clear_out();
    write_cycle(4'b1111, 32'h10, 32'h11, 32'h12, 32'h13);
    wait_drain();
    checks++;
    if (out_src.size() != 4) begin
      failures++;
      $display("FAIL all4_count: got %0d outputs, required 4", out_src.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_src[i] !== i[1:0] || out_dat[i] !== 32'h10 + i) begin
          failures++;
          $display("FAIL all4_order[%0d]: got src=%0d data=%h, required src=%0d data=%h", i, out_src[i], out_dat[i], i, 32'h10 + i);
        end
        if (i > 0) begin
          checks++;
          if (out_cyc[i] != out_cyc[i-1] + 1) begin
            failures++;
            $display("FAIL all4_b2b[%0d]: got gap %0d cycles, required 1", i, out_cyc[i] - out_cyc[i-1]);
          end
        end
      end
    end
    clear_out();
    write_cycle(4'b0101, 32'h30, 32'h0, 32'h32, 32'h0);
    wait_drain();
    checks++;
    if (out_src.size() != 2 || out_src[0] !== 2'd0 || out_src[1] !== 2'd2) begin
      failures++;
      $display("FAIL rr_02_order: got %0d outputs first src=%0d, required order 0,2", out_src.size(), (out_src.size() > 0) ? out_src[0] : 2'd3);
    end
  endtask

  task automatic test_fairness();
    int repeats = 0;
    int n1 = 0;
    int n3 = 0;
    int diff;
    clear_out();
    for (int c = 0; c < 100; c++)
      write_cycle(4'b1010 & src_ready, 32'h0, 32'h1000 + c, 32'h0, 32'h3000 + c);
    wait_drain();
    for (int i = 0; i < out_src.size(); i++) begin
      if (out_src[i] == 2'd1) n1++;
      if (out_src[i] == 2'd3) n3++;
      if (i > 0 && out_src[i] == out_src[i-1]) repeats++;
    end
    diff = (n1 > n3) ? n1 - n3 : n3 - n1;
    checks++; if (repeats != 0) begin failures++; $display("FAIL fair_alternate: got %0d back-to-back repeats, required 0", repeats); end
    checks++; if (diff > 1) begin failures++; $display("FAIL fair_balance: got n1=%0d n3=%0d, required difference <=1", n1, n3); end
    checks++; if (n1 + n3 < 100) begin failures++; $display("FAIL fair_volume: got %0d grants, required >=100", n1 + n3); end
    checks++; if (overflow_err !== 4'b0000) begin failures++; $display("FAIL fair_ovf: got %b, required 0000", overflow_err); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    clear_out();
    rsp_full = 1'b1;
    write_cycle(4'b0100, 32'h0, 32'h0, 32'h20, 32'h0);
    write_cycle(4'b0100, 32'h0, 32'h0, 32'h21, 32'h0);
    repeat (8) begin
      @(negedge clk);
      if (rsp_write_en) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_stall: got %0d writes while full, required 0", bad); end
    checks++; if (src_ready[2] !== 1'b0) begin failures++; $display("FAIL bp_ready: got %b, required 0", src_ready[2]); end
    @(posedge clk); #1;
    rsp_full = 1'b0;
    wait_drain();
    checks++;
    if (out_dat.size() != 2 || out_dat[0] !== 32'h20 || out_dat[1] !== 32'h21) begin
      failures++;
      $display("FAIL bp_release: got %0d words, required 00000020 then 00000021 once each", out_dat.size());
    end
  endtask

  task automatic test_overflow();
    clear_out();
    rsp_full = 1'b1;
    write_cycle(4'b0010, 32'h0, 32'h40, 32'h0, 32'h0);
    write_cycle(4'b0010, 32'h0, 32'h41, 32'h0, 32'h0);
    write_cycle(4'b0010, 32'h0, 32'hDEAD, 32'h0, 32'h0);
    checks++; if (overflow_err !== exp_ovf) begin failures++; $display("FAIL ovf_set: got %b, required %b", overflow_err, exp_ovf); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (overflow_err !== exp_ovf) begin failures++; $display("FAIL ovf_hold: got %b, required %b", overflow_err, exp_ovf); end
    rsp_full = 1'b0;
    wait_drain();
    checks++;
    if (out_dat.size() != 2 || out_dat[0] !== 32'h40 || out_dat[1] !== 32'h41) begin
      failures++;
      $display("FAIL ovf_words: got %0d words, required only 00000040 and 00000041", out_dat.size());
    end
    checks++; if (overflow_err !== exp_ovf) begin failures++; $display("FAIL ovf_sticky: got %b, required %b", overflow_err, exp_ovf); end
  endtask

  task automatic test_reset_mid();
    rsp_full = 1'b1;
    write_cycle(4'b1011, 32'h50, 32'h51, 32'h0, 32'h53);
    write_cycle(4'b1011, 32'h60, 32'h61, 32'h0, 32'h63);
    rsp_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_write_en !== 1'b1) begin failures++; $display("FAIL mid_active: got wen %b before reset, required 1", rsp_write_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rsp_write_en !== 1'b0) begin failures++; $display("FAIL mid_wen: got %b, required 0", rsp_write_en); end
    checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL mid_data: got %h, required 0", rsp_data); end
    checks++; if (rsp_src_id !== 2'd0) begin failures++; $display("FAIL mid_src: got %0d, required 0", rsp_src_id); end
    checks++; if (overflow_err !== 4'b0000) begin failures++; $display("FAIL mid_ovf: got %b, required 0000", overflow_err); end
    exp_q.delete();
    exp_ovf = '0;
    clear_out();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (src_ready !== 4'b1111) begin failures++; $display("FAIL mid_ready: got %b, required 1111", src_ready); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (out_src.size() != 0) begin failures++; $display("FAIL mid_stale: got %0d outputs after reset, required 0", out_src.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    wait_drain();
    test_all_four();
    test_fairness();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d pending words, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
